// File: rtl/qed_instruction_dup.sv
// SQED instruction duplicator: forwards legal originals while recording them,
// then replays them with register indices remapped into the upper register half.
module qed_instruction_dup #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             qed_exec_dup,
    input  logic             stall,
    output logic [31:0]      qed_ifu_instruction,
    output logic             qed_vld_out,
    output logic [CNT_W-1:0] qed_fifo_count,
    output logic             qed_fifo_full,
    output logic             qed_fifo_empty
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [6:0]  OP_R  = 7'b0110011;
    localparam logic [6:0]  OP_I  = 7'b0010011;
    localparam logic [6:0]  OP_LD = 7'b0000011;
    localparam logic [6:0]  OP_ST = 7'b0100011;

    // Which register fields an opcode actually uses: {rd, rs1, rs2}; 3'b000 means unsupported.
    function automatic logic [2:0] used_fields(input logic [6:0] opcode);
        logic [2:0] u;
        case (opcode)
            OP_R:        u = 3'b111;
            OP_I, OP_LD: u = 3'b110;
            OP_ST:       u = 3'b011;
            default:     u = 3'b000;
        endcase
        return u;
    endfunction

    function automatic logic is_legal(input logic [31:0] ins);
        logic [2:0] u;
        u = used_fields(ins[6:0]);
        return (u != 3'b000) && !(u[2] && ins[11]) && !(u[1] && ins[19]) && !(u[0] && ins[24]);
    endfunction

    // Stored words are legal, so the upper-half bit of each used field is known to be 0.
    function automatic logic [31:0] remap(input logic [31:0] ins);
        logic [2:0]  u;
        logic [31:0] r;
        u     = used_fields(ins[6:0]);
        r     = ins;
        r[11] = ins[11] | (u[2] & (|ins[11:7]));
        r[19] = ins[19] | (u[1] & (|ins[19:15]));
        r[24] = ins[24] | (u[0] & (|ins[24:20]));
        return r;
    endfunction

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_out;
    logic             r_vld;

    logic [PTR_W-1:0] w_nxt_wp;
    logic [PTR_W-1:0] w_nxt_rp;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [31:0]      w_nxt_out;
    logic             w_nxt_vld;
    logic             w_push;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_empty = (r_cnt == {CNT_W{1'b0}});

    // Next-state decision: stall holds everything, otherwise mode picks push or pop.
    always_comb begin
        w_nxt_wp  = r_wp;
        w_nxt_rp  = r_rp;
        w_nxt_cnt = r_cnt;
        w_nxt_out = r_out;
        w_nxt_vld = r_vld;
        w_push    = 1'b0;
        if (stall) begin
            w_push = 1'b0;
        end else if (qed_exec_dup) begin
            if (!w_empty) begin
                w_nxt_out = remap(r_mem[r_rp]);
                w_nxt_vld = 1'b1;
                w_nxt_rp  = r_rp + PTR_W'(1);
                w_nxt_cnt = r_cnt - CNT_W'(1);
            end else begin
                w_nxt_out = NOP;
                w_nxt_vld = 1'b0;
            end
        end else begin
            if (is_legal(instruction) && !w_full) begin
                w_push    = 1'b1;
                w_nxt_out = instruction;
                w_nxt_vld = 1'b1;
                w_nxt_wp  = r_wp + PTR_W'(1);
                w_nxt_cnt = r_cnt + CNT_W'(1);
            end else begin
                w_nxt_out = NOP;
                w_nxt_vld = 1'b0;
            end
        end
    end

    // Control and output registers; reset overrides stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= {PTR_W{1'b0}};
            r_rp  <= {PTR_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            r_out <= NOP;
            r_vld <= 1'b0;
        end else begin
            r_wp  <= w_nxt_wp;
            r_rp  <= w_nxt_rp;
            r_cnt <= w_nxt_cnt;
            r_out <= w_nxt_out;
            r_vld <= w_nxt_vld;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wp] <= instruction;
        end
    end

    assign qed_ifu_instruction = r_out;
    assign qed_vld_out         = r_vld;
    assign qed_fifo_count      = r_cnt;
    assign qed_fifo_full       = w_full;
    assign qed_fifo_empty      = w_empty;

endmodule
